// File: rtl/pll_reset_seq_pkg.sv
// Shared types and default cycle constants for the PLL reset sequencer.
package pll_reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_REL_MEM   = 2'd1,
        ST_RUN       = 2'd2,
        ST_PLL_KICK  = 2'd3
    } state_t;

    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 32'd1024;
    localparam int unsigned DEF_MEM_TO_CPU_CYCLES   = 32'd256;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 32'd65536;
    localparam int unsigned DEF_PLL_RST_CYCLES      = 32'd16;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_seq_sync2.sv
// Generic two-flop synchroniser with asynchronous active-low clear to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of an asynchronous level into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock qualifier and ordered memory/CPU reset release.
// Optional PLL watchdog enabled by defining PLL_RESET_SEQ_WATCHDOG_EN.
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned MEM_TO_CPU_CYCLES   = DEF_MEM_TO_CPU_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pll_locked,
    input  logic       btn_rst_n,
    output logic       pll_rst,
    output logic       rst_mem,
    output logic       rst_cpu,
    output logic       ready,
    output logic [3:0] kick_cnt
);

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam int unsigned CNT_MAX = max2(max2(LOCK_STABLE_CYCLES, MEM_TO_CPU_CYCLES),
        WD_EN ? max2(LOCK_TIMEOUT_CYCLES, PLL_RST_CYCLES) : 32'd0);
    localparam int unsigned CW = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] ONE         = CW'(1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(MEM_TO_CPU_CYCLES - 1);

    logic          lock_s;
    logic          btn_s;
    logic          go_s;
    state_t        state_r;
    state_t        state_nx_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx_s;
    logic          rst_mem_r;
    logic          rst_cpu_r;
    logic          ready_r;

    sync2 u_lock_sync (.clk(clk), .rst_n(rstn), .d(pll_locked), .q(lock_s));
    sync2 u_btn_sync  (.clk(clk), .rst_n(rstn), .d(btn_rst_n),  .q(btn_s));

    assign go_s = lock_s & btn_s;

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] KICK_LAST = CW'(PLL_RST_CYCLES - 1);
    logic [CW-1:0] tmo_r;
    logic [CW-1:0] tmo_nx_s;
    logic          pll_rst_r;
    logic [3:0]    kick_cnt_r;
`endif

    // Next-state and counter logic; cnt_r is the stable, delay or kick counter by state
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
        tmo_nx_s   = '0;
`endif
        case (state_r)
            ST_WAIT_LOCK: begin
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
                tmo_nx_s = tmo_r + ONE;
`endif
                if (go_s && (cnt_r == STABLE_LAST)) begin
                    state_nx_s = ST_REL_MEM;
                    cnt_nx_s   = '0;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
                end else if (tmo_r == TMO_LAST) begin
                    state_nx_s = ST_PLL_KICK;
                    cnt_nx_s   = '0;
`endif
                end else if (go_s) begin
                    cnt_nx_s = cnt_r + ONE;
                end else begin
                    cnt_nx_s = '0;
                end
            end
            ST_REL_MEM: begin
                if (!go_s) begin
                    state_nx_s = ST_WAIT_LOCK;
                    cnt_nx_s   = '0;
                end else if (cnt_r == DELAY_LAST) begin
                    state_nx_s = ST_RUN;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s = cnt_r + ONE;
                end
            end
            ST_RUN: begin
                if (!go_s) begin
                    state_nx_s = ST_WAIT_LOCK;
                end else begin
                    state_nx_s = ST_RUN;
                end
                cnt_nx_s = '0;
            end
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
            // The kick pulse always runs to completion, whatever go_s does
            ST_PLL_KICK: begin
                if (cnt_r == KICK_LAST) begin
                    state_nx_s = ST_WAIT_LOCK;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s = cnt_r + ONE;
                end
            end
`endif
            default: begin
                state_nx_s = ST_WAIT_LOCK;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // State register and outputs decoded from the next state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_WAIT_LOCK;
            cnt_r      <= '0;
            rst_mem_r  <= 1'b1;
            rst_cpu_r  <= 1'b1;
            ready_r    <= 1'b0;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
            tmo_r      <= '0;
            pll_rst_r  <= 1'b0;
            kick_cnt_r <= 4'd0;
`endif
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            rst_mem_r  <= !((state_nx_s == ST_REL_MEM) || (state_nx_s == ST_RUN));
            rst_cpu_r  <= (state_nx_s != ST_RUN);
            ready_r    <= (state_nx_s == ST_RUN);
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
            tmo_r      <= tmo_nx_s;
            pll_rst_r  <= (state_nx_s == ST_PLL_KICK);
            if ((state_nx_s == ST_PLL_KICK) && (state_r != ST_PLL_KICK) && (kick_cnt_r != 4'd15)) begin
                kick_cnt_r <= kick_cnt_r + 4'd1;
            end else begin
                kick_cnt_r <= kick_cnt_r;
            end
`endif
        end
    end

    assign rst_mem = rst_mem_r;
    assign rst_cpu = rst_cpu_r;
    assign ready   = ready_r;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    assign pll_rst  = pll_rst_r;
    assign kick_cnt = kick_cnt_r;
`else
    assign pll_rst  = 1'b0;
    assign kick_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed self-checking bench for pll_reset_seq (small cycle parameters).
module tb_pll_reset_seq;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pll_locked;
    logic       btn_rst_n;
    logic       pll_rst;
    logic       rst_mem;
    logic       rst_cpu;
    logic       ready;
    logic [3:0] kick_cnt;

    int checks   = 0;
    int failures = 0;

    pll_reset_seq #(
        .LOCK_STABLE_CYCLES (8),
        .MEM_TO_CPU_CYCLES  (4),
        .LOCK_TIMEOUT_CYCLES(64),
        .PLL_RST_CYCLES     (3)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .pll_locked(pll_locked),
        .btn_rst_n (btn_rst_n),
        .pll_rst   (pll_rst),
        .rst_mem   (rst_mem),
        .rst_cpu   (rst_cpu),
        .ready     (ready),
        .kick_cnt  (kick_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic m, input logic c, input logic r);
        chk({tag, "_rst_mem"}, {3'd0, rst_mem}, {3'd0, m});
        chk({tag, "_rst_cpu"}, {3'd0, rst_cpu}, {3'd0, c});
        chk({tag, "_ready"},   {3'd0, ready},   {3'd0, r});
    endtask

    logic seen_kick;

    initial begin
        rstn       = 1'b0;
        pll_locked = 1'b0;
        btn_rst_n  = 1'b1;
        step(3);
        chk_outs("reset", 1'b1, 1'b1, 1'b0);
        chk("reset_pll_rst", {3'd0, pll_rst}, 4'd0);
        chk("reset_kick_cnt", kick_cnt, 4'd0);

        // Clean lock: lock raised right after edge 0
        rstn       = 1'b1;
        pll_locked = 1'b1;
        step(9);
        chk_outs("clean_e9", 1'b1, 1'b1, 1'b0);
        step(1);
        chk_outs("clean_e10", 1'b0, 1'b1, 1'b0);
        step(3);
        chk_outs("clean_e13", 1'b0, 1'b1, 1'b0);
        step(1);
        chk_outs("clean_e14", 1'b0, 1'b0, 1'b1);

        // Loss of lock in RUN, then relock
        step(2);
        pll_locked = 1'b0;
        step(2);
        chk_outs("loss_e2", 1'b0, 1'b0, 1'b1);
        step(1);
        chk_outs("loss_e3", 1'b1, 1'b1, 1'b0);
        pll_locked = 1'b1;
        step(9);
        chk_outs("relock_e9", 1'b1, 1'b1, 1'b0);
        step(1);
        chk_outs("relock_e10", 1'b0, 1'b1, 1'b0);
        step(4);
        chk_outs("relock_e14", 1'b0, 1'b0, 1'b1);

        // Glitch in WAIT_LOCK: 5 high, 1 low, then high
        pll_locked = 1'b0;
        step(5);
        chk_outs("glitch_wait", 1'b1, 1'b1, 1'b0);
        pll_locked = 1'b1;
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step(1);
            chk("glitch_hold_rst_mem", {3'd0, rst_mem}, 4'd1);
        end
        step(1);
        chk_outs("glitch_e10", 1'b0, 1'b1, 1'b0);
        step(4);
        chk_outs("glitch_e14", 1'b0, 1'b0, 1'b1);

        // Button pulse low for 2 cycles in RUN
        btn_rst_n = 1'b0;
        step(2);
        btn_rst_n = 1'b1;
        step(1);
        chk_outs("btn_e3", 1'b1, 1'b1, 1'b0);
        step(8);
        chk_outs("btn_e11", 1'b1, 1'b1, 1'b0);
        step(1);
        chk_outs("btn_e12", 1'b0, 1'b1, 1'b0);
        step(4);
        chk_outs("btn_e16", 1'b0, 1'b0, 1'b1);

        // Async reset in the middle of REL_MEM
        pll_locked = 1'b0;
        step(4);
        pll_locked = 1'b1;
        step(11);
        chk_outs("async_relmem", 1'b0, 1'b1, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk_outs("async_immediate", 1'b1, 1'b1, 1'b0);
        step(2);
        rstn = 1'b1;
        step(9);
        chk_outs("async_restart_e9", 1'b1, 1'b1, 1'b0);
        step(1);
        chk_outs("async_restart_e10", 1'b0, 1'b1, 1'b0);
        step(4);
        chk_outs("async_restart_e14", 1'b0, 1'b0, 1'b1);

        // Never-locking PLL from a fresh reset
        rstn = 1'b0;
        step(1);
        rstn       = 1'b1;
        pll_locked = 1'b0;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
        step(63);
        chk("wd_e63_pll_rst", {3'd0, pll_rst}, 4'd0);
        chk("wd_e63_kick_cnt", kick_cnt, 4'd0);
        step(1);
        chk("wd_e64_pll_rst", {3'd0, pll_rst}, 4'd1);
        chk("wd_e64_kick_cnt", kick_cnt, 4'd1);
        chk_outs("wd_kick", 1'b1, 1'b1, 1'b0);
        step(2);
        chk("wd_e66_pll_rst", {3'd0, pll_rst}, 4'd1);
        step(1);
        chk("wd_e67_pll_rst", {3'd0, pll_rst}, 4'd0);
        for (int k = 2; k <= 17; k++) begin
            step(63);
            chk("wd_gap_pll_rst", {3'd0, pll_rst}, 4'd0);
            step(1);
            chk("wd_kick_pll_rst", {3'd0, pll_rst}, 4'd1);
            chk("wd_kick_cnt", kick_cnt, (k > 15) ? 4'd15 : 4'(k));
            step(3);
        end
`else
        seen_kick = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (pll_rst !== 1'b0) seen_kick = 1'b1;
        end
        chk("nowd_pll_rst_never", {3'd0, seen_kick}, 4'd0);
        chk("nowd_kick_cnt", kick_cnt, 4'd0);
        chk_outs("nowd_wait", 1'b1, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Reset sequencer directly downstream of the board PLL. Qualifies the PLL `locked` flag, then releases the memory-side and CPU-side resets in a fixed order. Runs on the stable 25 MHz board oscillator, so it keeps working while the PLL outputs are absent or unstable. Each output reset is re-synchronised into its consuming clock domain by that domain's own 2-flop reset synchroniser, outside this block.

## Interface

Parameters:
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronised-locked cycles required before release.
- `MEM_TO_CPU_CYCLES`, 256: cycles from `rst_mem` release to `rst_cpu` release.
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles in WAIT_LOCK before the PLL is kicked (watchdog only).
- `PLL_RST_CYCLES`, 16: width of the `pll_rst` pulse in cycles (watchdog only).

Ports:
- `clk` in 1: 25 MHz oscillator clock (PLL reference input).
- `rstn` in 1: asynchronous, active-low block reset.
- `pll_locked` in 1: PLL lock flag; asynchronous to `clk`.
- `btn_rst_n` in 1: user reset button, active-low, asynchronous.
- `pll_rst` out 1: active-high PLL reset request.
- `rst_mem` out 1: active-high reset for the SDRAM/memory domain.
- `rst_cpu` out 1: active-high reset for the CPU/system domain.
- `ready` out 1: high when both resets are released.
- `kick_cnt` out 4: saturating count of PLL kicks (watchdog only).

## Operation

- `pll_locked` and `btn_rst_n` each pass through a 2-flop synchroniser, giving `lock_s` and `btn_s`. Both synchroniser chains reset to 0.
- `go = lock_s & btn_s`.
- State machine states: WAIT_LOCK, REL_MEM, RUN, PLL_KICK (PLL_KICK exists only with the watchdog).
- **WAIT_LOCK:**
  - `rst_mem` = 1 and `rst_cpu` = 1.
  - The stable counter increments while `go` is high and clears to 0 when `go` is low.
  - When the stable counter equals `LOCK_STABLE_CYCLES-1` with `go` high, transition to REL_MEM.
- **REL_MEM:**
  - `rst_mem` = 0 and `rst_cpu` = 1.
  - The delay counter counts from 0. At `MEM_TO_CPU_CYCLES-1`, transition to RUN.
- **RUN:** `rst_mem` = 0, `rst_cpu` = 0, `ready` = 1.
- **Loss of `go` in REL_MEM or RUN:** on the next edge, enter WAIT_LOCK. Both resets assert and all counters clear.
- All outputs are registered, decoded from the next state.
- Counter width is `$clog2` of the largest active parameter plus 1. Counters never wrap: the comparisons above stop them before overflow.
- **Reset values (`rstn` low):**
  - State is WAIT_LOCK.
  - `rst_mem` = 1, `rst_cpu` = 1, `ready` = 0, `pll_rst` = 0, `kick_cnt` = 0.
  - Asserting `rstn` mid-sequence forces these values immediately, asynchronously.
- **Simultaneous events:** in PLL_KICK, the pulse always completes, regardless of `go`.

## Timing

- `rst_mem` falls on the (`LOCK_STABLE_CYCLES`+2)th rising edge after `pll_locked` is first sampled high, provided `btn_rst_n` is high and stays high.
- `rst_cpu` and `ready` change on exactly `MEM_TO_CPU_CYCLES` edges after the `rst_mem` fall.
- Loss-of-lock response: both resets are high on the 3rd edge after `pll_locked` is sampled low (2 synchroniser stages plus 1 registered output).
- A lock glitch shorter than `LOCK_STABLE_CYCLES` in WAIT_LOCK restarts qualification and produces no output change.

## Configuration

- Macro: `PLL_RESET_SEQ_WATCHDOG_EN`.
- **Defined:**
  - The timeout counter runs in WAIT_LOCK from entry. It restarts on every entry to WAIT_LOCK and is independent of `go`.
  - Reaching `LOCK_TIMEOUT_CYCLES-1` enters PLL_KICK.
  - PLL_KICK holds `pll_rst` = 1 for exactly `PLL_RST_CYCLES` cycles and increments `kick_cnt`, saturating at 15. It then returns to WAIT_LOCK.
  - Resets stay asserted throughout PLL_KICK.
- **Undefined:**
  - There is no PLL_KICK state and no timeout counter.
  - `pll_rst` and `kick_cnt` are tied to 0.
  - WAIT_LOCK waits indefinitely.

## Structure

- Shared package `pll_reset_seq_pkg` holds:
  - the state enum (`ST_WAIT_LOCK`, `ST_REL_MEM`, `ST_RUN`, `ST_PLL_KICK`);
  - the default cycle constants.
- One sub-module, `sync2`: a generic 2-flop synchroniser with async active-low clear, instantiated twice.

## Test plan

Use parameters `LOCK_STABLE_CYCLES`=8, `MEM_TO_CPU_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=64, `PLL_RST_CYCLES`=3.

- **Clean lock:** raise `pll_locked` at edge 0 -> `rst_mem` falls at edge 10, `rst_cpu` and `ready` at edge 14.
- **Glitch:** lock high 5 cycles, low 1, then high -> no release until 8 consecutive synchronised-high cycles; `rst_mem` falls 10 edges after the final rise.
- **Loss of lock in RUN:** drop `pll_locked` -> `rst_mem`=`rst_cpu`=1 and `ready`=0 at the 3rd edge; after relock the full 10/14 sequence repeats.
- **Button:** pulse `btn_rst_n` low 2 cycles in RUN -> both resets assert; after release, the sequence restarts with the same timing as a clean lock.
- **Watchdog (macro defined), never lock:** `pll_rst` high for 3 cycles after 64 cycles in WAIT_LOCK; `kick_cnt` 1, 2, …, saturating at 15 after 15 kicks. With the macro undefined: `pll_rst` stays 0 forever.
- **Async reset:** assert `rstn` mid-REL_MEM -> outputs go to reset values immediately, without waiting for a clock edge; on deassert the sequence restarts from WAIT_LOCK.
